// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Optional feature: define ALU_ARB_OPC_CHECK_EN to suppress opcode 3'b111 and flag it on err.
module alu_arb #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  opc0,
  input  logic [2:0]  opc1,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  input  logic        c0,
  input  logic        c1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [2:0]  alu_opc,
  output logic [15:0] alu_ina,
  output logic [15:0] alu_inb,
  output logic        alu_inc,
  input  logic [15:0] alu_w,
  input  logic        alu_zer,
  input  logic        alu_neg,
  output logic [15:0] res,
  output logic        res_zer,
  output logic        res_neg,
  output logic        res_id,
  output logic        err,
  output logic        busy
);

  localparam int unsigned CW = 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          ptr;
  logic          take, win, capture;
  logic [2:0]    opc_sel;

  // Arbitration and next-state decision
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    capture  = 1'b0;
    win      = (req0 && req1) ? ptr : req1;
    opc_sel  = win ? opc1 : opc0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          take     = 1'b1;
          state_nx = S_EXEC;
          cnt_nx   = CW'(LAT);
        end
      end
      S_EXEC: begin
        if (cnt <= CW'(1)) begin
          capture  = 1'b1;
          state_nx = S_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

`ifdef ALU_ARB_OPC_CHECK_EN
  logic bad, err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Registered outputs; alu_* double as the in-flight operand latch
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
      ptr     <= 1'b0;
      alu_opc <= '0;
      alu_ina <= '0;
      alu_inb <= '0;
      alu_inc <= 1'b0;
      res     <= '0;
      res_zer <= 1'b0;
      res_neg <= 1'b0;
      res_id  <= 1'b0;
`ifdef ALU_ARB_OPC_CHECK_EN
      bad     <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      gnt0  <= take & ~win;
      gnt1  <= take & win;
      done0 <= capture & ~res_id;
      done1 <= capture & res_id;
      busy  <= (state_nx != S_IDLE);
      if (state == S_DONE) ptr <= ~res_id;
      if (take) begin
        res_id  <= win;
        alu_ina <= win ? a1 : a0;
        alu_inb <= win ? b1 : b0;
        alu_inc <= win ? c1 : c0;
`ifdef ALU_ARB_OPC_CHECK_EN
        bad     <= (opc_sel == 3'b111);
        alu_opc <= (opc_sel == 3'b111) ? 3'b000 : opc_sel;
`else
        alu_opc <= opc_sel;
`endif
      end else if (capture) begin
        alu_opc <= '0;
        alu_ina <= '0;
        alu_inb <= '0;
        alu_inc <= 1'b0;
`ifdef ALU_ARB_OPC_CHECK_EN
        err_q <= bad;
        if (!bad) begin
          res     <= alu_w;
          res_zer <= alu_zer;
          res_neg <= alu_neg;
        end
`else
        res     <= alu_w;
        res_zer <= alu_zer;
        res_neg <= alu_neg;
`endif
      end
    end
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning the number of EXEC cycles the shared ALU is driven before its result is captured; legal range is 1..7.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports req0/req1, input, 1, the requester k operation request.
REQ-005 SHALL have ports opc0/opc1, input, 3; a0/a1, input, 16; b0/b1, input, 16; c0/c1, input, 1: requester k opcode, operand A, operand B and carry-in.
REQ-006 SHALL have ports gnt0/gnt1, output, 1, a one-cycle pulse meaning requester k's operands were latched.
REQ-007 SHALL have ports done0/done1, output, 1, a one-cycle pulse meaning requester k's result is valid.
REQ-008 SHALL have port alu_opc, output, 3; alu_ina, output, 16; alu_inb, output, 16; alu_inc, output, 1; together these drive the shared combinational ALU.
REQ-009 SHALL have ports alu_w, input, 16; alu_zer, input, 1; alu_neg, input, 1; these are the ALU result and flags.
REQ-010 SHALL have ports res, output, 16; res_zer, output, 1; res_neg, output, 1; res_id, output, 1; err, output, 1: the registered result, its flags, the served requester and the error flag.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-013 IDLE: if req0 or req1 is sampled high, SHALL latch the winner's opc/a/b/c and set res_id to the winner, then enter EXEC, with gnt of the winner high for exactly the first EXEC cycle.
REQ-014 Arbitration SHALL be round-robin via a 1-bit pointer ptr: a single request wins outright; when both are requesting, requester ptr wins.
REQ-015 EXEC SHALL drive alu_* from the latched registers for LAT cycles, counted by a 3-bit down-counter loaded with LAT; on the clock edge that ends the last EXEC cycle, alu_w/alu_zer/alu_neg SHALL be captured into res/res_zer/res_neg, and the state SHALL go to DONE.
REQ-016 DONE SHALL last one cycle with done[res_id]=1, set ptr = ~res_id, and return to IDLE.
REQ-017 Latency SHALL be as follows: request sampled at edge N, gnt during cycle N+1, done during cycle N+LAT+1, next grant no earlier than cycle N+LAT+3.
REQ-018 req during EXEC/DONE SHALL be ignored; a req still high when back in IDLE SHALL count as a new request; requesters drop req on seeing gnt.
REQ-019 In IDLE, alu_* outputs SHALL be 0; res/res_zer/res_neg/res_id/err SHALL hold their last captured values until the next capture.
REQ-020 Operand changes on a0/b0/a1/b1 after gnt SHALL NOT affect the operation in flight.
REQ-021 The block SHALL perform no arithmetic itself; widths SHALL pass through unmodified.

Reset
REQ-022 When rst=1 at a clock edge, SHALL set state=IDLE, ptr=0, counter=0, and every output (gnt*, done*, res, res_zer, res_neg, res_id, err, busy, alu_*) to 0.
REQ-023 Reset during EXEC/DONE SHALL abort the operation with no done pulse; rst SHALL take priority over any request in the same cycle.

Configuration
REQ-024 With macro ALU_ARB_OPC_CHECK_EN defined, opcode 3'b111 SHALL be granted normally but not issued: alu_opc SHALL be driven with 0, res/res_zer/res_neg SHALL be left unchanged at capture, and err=1 SHALL be registered alongside done; every other opcode SHALL set err=0.
REQ-025 Without ALU_ARB_OPC_CHECK_EN, all opcodes SHALL pass through to the ALU and err SHALL be tied to 0.

Verification
REQ-026 LAT=1, req0 only, opc0=010, a0=0x0003, b0=0x0004, c0=1 -> gnt0 in cycle 1, done0 in cycle 2, res=0x0008, res_zer=0, res_neg=0, res_id=0.
REQ-027 req0 and req1 high together after reset, opc0=000 a0=0x0001, opc1=110 a1=0x12AB b1=0x34CD, both held high until granted -> req0 served first: res=0xFFFF, res_neg=1; req1 served next: res=0xABCD, res_id=1.
REQ-028 Both requesters held high continuously -> grants alternate 0,1,0,1 with no starvation.
REQ-029 LAT=3, opc=011, a=0x0010, b=0xFFFE, plus a change to a0 during EXEC -> done three cycles after gnt, res=0x000F, and the operand change has no effect.
REQ-030 rst pulsed in the second EXEC cycle (LAT=3) -> no done pulse, all outputs 0, and the next simultaneous request goes to requester 0.
REQ-031 With ALU_ARB_OPC_CHECK_EN, opc=111 -> done with err=1 and res unchanged; without the macro -> res=0x0000, res_zer=1, err=0.
